// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter.
// Direction and boundary-mode encodings match the raw up/sat input levels.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Generic clamp; callers size the result back down to their own width.
    function automatic logic [31:0] clamp(input logic [31:0] val, input logic [31:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage : counter_pkg

// File: rtl/counter_updown_nxt.sv
// Next-state logic for counter_updown: load clamp, step, wrap and saturation.
// Purely combinational; clear and reset are applied by the register stage.
module counter_updown_nxt
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MOD_MAX = 15
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt_nxt,
    output logic             wrap_nxt,
    output logic             sat_set
);

    // One extra bit keeps +1 exact when MOD_MAX is the all-ones value.
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MOD_MAX);

    logic [WIDTH:0] cnt_ext;
    assign cnt_ext = {1'b0, cnt};

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        sat_set  = 1'b0;

        if (load) begin
            cnt_nxt = WIDTH'(clamp(32'(load_val), 32'(MOD_MAX)));
        end else if (en) begin
            if (up == DIR_UP) begin
                if (cnt_ext < MAX_EXT) begin
                    cnt_nxt = WIDTH'(cnt_ext + 1'b1);
                end else if (sat == MODE_SAT) begin
                    sat_set = 1'b1;
                end else begin
                    cnt_nxt  = '0;
                    wrap_nxt = 1'b1;
                end
            end else begin
                if (cnt_ext != '0) begin
                    cnt_nxt = WIDTH'(cnt_ext - 1'b1);
                end else if (sat == MODE_SAT) begin
                    sat_set = 1'b1;
                end else begin
                    cnt_nxt  = WIDTH'(MAX_EXT);
                    wrap_nxt = 1'b1;
                end
            end
        end
    end

endmodule : counter_updown_nxt

// File: rtl/counter_updown.sv
// Modulo-N up/down counter with clear, clamped load, wrap/saturate modes,
// combinational terminal count, registered wrap pulse and sticky saturation flag.
module counter_updown
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MOD_MAX = 15,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap,
    output logic             sat_flag
);

    if (MOD_MAX < 1 || MOD_MAX > (2**WIDTH) - 1) begin : g_bad_mod_max
        $error("counter_updown: MOD_MAX out of range for WIDTH");
    end
    if (RST_VAL > MOD_MAX) begin : g_bad_rst_val
        $error("counter_updown: RST_VAL exceeds MOD_MAX");
    end

    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD_MAX);

    logic [WIDTH-1:0] cnt_q, cnt_d, cnt_nxt;
    logic             wrap_q, wrap_d, wrap_nxt;
    logic             sat_flag_q, sat_flag_d, sat_set;

    counter_updown_nxt #(
        .WIDTH   (WIDTH),
        .MOD_MAX (MOD_MAX)
    ) u_nxt (
        .cnt      (cnt_q),
        .en       (en),
        .up       (up),
        .sat      (sat),
        .load     (load),
        .load_val (load_val),
        .cnt_nxt  (cnt_nxt),
        .wrap_nxt (wrap_nxt),
        .sat_set  (sat_set)
    );

    // Clear overrides load and count; reset is layered on top in the register.
    always_comb begin
        cnt_d      = cnt_nxt;
        wrap_d     = wrap_nxt;
        sat_flag_d = sat_flag_q | sat_set;
        if (clr) begin
            cnt_d      = RST_CNT;
            wrap_d     = 1'b0;
            sat_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values together.
        if (rst) begin
            cnt_q      <= RST_CNT;
            wrap_q     <= 1'b0;
            sat_flag_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    assign tc = en & (((up == DIR_UP)   && (cnt_q == MAX_CNT)) ||
                      ((up == DIR_DOWN) && (cnt_q == '0)));

    assign cnt      = cnt_q;
    assign wrap     = wrap_q;
    assign sat_flag = sat_flag_q;

endmodule : counter_updown

// File: tb/tb_counter_updown.sv
// Scoreboard bench for counter_updown: a MOD_MAX=9 and a MOD_MAX=15 instance
// share stimulus; expected states are queued per edge and compared after it.
module tb_counter_updown;

    typedef struct packed {
        logic [3:0] cnt;
        logic       wrap;
        logic       sat_flag;
    } obs_t;

    typedef struct packed {
        logic       rst, clr, load, en, up, sat;
        logic [3:0] lv;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst, clr, load, en, up, sat;
    logic [3:0] load_val;
    logic [3:0] cnt9, cnt15;
    logic       tc9, tc15, wrap9, wrap15, sf9, sf15;

    int   errors = 0;
    int   checks = 0;
    obs_t m9, m15;
    bit   model_valid = 1'b0;
    obs_t exp9_q[$];
    obs_t exp15_q[$];

    always #5 clk = ~clk;

    counter_updown #(.WIDTH(4), .MOD_MAX(9), .RST_VAL(0)) dut9 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .sat(sat),
        .cnt(cnt9), .tc(tc9), .wrap(wrap9), .sat_flag(sf9)
    );

    counter_updown #(.WIDTH(4), .MOD_MAX(15), .RST_VAL(0)) dut15 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .sat(sat),
        .cnt(cnt15), .tc(tc15), .wrap(wrap15), .sat_flag(sf15)
    );

    function automatic stim_t mk(input logic r, input logic c, input logic l,
                                 input logic e, input logic u, input logic s,
                                 input int lv);
        stim_t t;
        t.rst = r; t.clr = c; t.load = l; t.en = e; t.up = u; t.sat = s;
        t.lv  = 4'(lv);
        return t;
    endfunction

    // Reference behaviour of one clock edge for a counter with range 0..maxv.
    function automatic obs_t model(input obs_t s, input int maxv);
        obs_t n;
        int   c;
        n      = s;
        n.wrap = 1'b0;
        c      = int'(s.cnt);
        if (rst || clr) begin
            n = '0;
        end else if (load) begin
            n.cnt = (int'(load_val) > maxv) ? 4'(maxv) : load_val;
        end else if (en && up) begin
            if (c < maxv)  n.cnt = 4'(c + 1);
            else if (sat)  n.sat_flag = 1'b1;
            else begin     n.cnt = 4'd0; n.wrap = 1'b1; end
        end else if (en) begin
            if (c > 0)     n.cnt = 4'(c - 1);
            else if (sat)  n.sat_flag = 1'b1;
            else begin     n.cnt = 4'(maxv); n.wrap = 1'b1; end
        end
        return n;
    endfunction

    function automatic logic exp_tc(input obs_t s, input int maxv);
        if (!en) return 1'b0;
        return up ? (int'(s.cnt) == maxv) : (s.cnt == 4'd0);
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rst; clr = s.clr; load = s.load;
        en  = s.en;  up  = s.up;  sat  = s.sat;
        load_val = s.lv;
    endtask

    // Advance both models, queue their expectations, then take the edge.
    task automatic tick();
        m9  = model(m9, 9);
        m15 = model(m15, 15);
        exp9_q.push_back(m9);
        exp15_q.push_back(m15);
        if (rst) model_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e9, e15;
        apply(mk(1, 0, 0, 0, 0, 0, 0));
        tick();
        e9  = exp9_q.pop_front();
        e15 = exp15_q.pop_front();
        checks++;
        if ({cnt9, wrap9, sf9} !== e9) begin
            errors++;
            $display("FAIL reset9: got cnt=%0d wrap=%b sf=%b, want cnt=%0d wrap=%b sf=%b",
                     cnt9, wrap9, sf9, e9.cnt, e9.wrap, e9.sat_flag);
        end
        checks++;
        if ({cnt15, wrap15, sf15} !== e15) begin
            errors++;
            $display("FAIL reset15: got cnt=%0d wrap=%b sf=%b, want cnt=%0d wrap=%b sf=%b",
                     cnt15, wrap15, sf15, e15.cnt, e15.wrap, e15.sat_flag);
        end
    endtask

    // Runs a stimulus list: tc is checked before each edge, state after it.
    task automatic run_seq(input string name, input stim_t seq[$]);
        obs_t e9, e15;
        foreach (seq[i]) begin
            apply(seq[i]);
            #1;
            if (model_valid && !rst) begin
                checks++;
                if (tc9 !== exp_tc(m9, 9)) begin
                    errors++;
                    $display("FAIL %s tc9 step %0d: got %b want %b", name, i, tc9, exp_tc(m9, 9));
                end
                checks++;
                if (tc15 !== exp_tc(m15, 15)) begin
                    errors++;
                    $display("FAIL %s tc15 step %0d: got %b want %b", name, i, tc15, exp_tc(m15, 15));
                end
            end
            tick();
            e9  = exp9_q.pop_front();
            e15 = exp15_q.pop_front();
            checks++;
            if ({cnt9, wrap9, sf9} !== e9) begin
                errors++;
                $display("FAIL %s dut9 step %0d: got cnt=%0d wrap=%b sf=%b, want cnt=%0d wrap=%b sf=%b",
                         name, i, cnt9, wrap9, sf9, e9.cnt, e9.wrap, e9.sat_flag);
            end
            checks++;
            if ({cnt15, wrap15, sf15} !== e15) begin
                errors++;
                $display("FAIL %s dut15 step %0d: got cnt=%0d wrap=%b sf=%b, want cnt=%0d wrap=%b sf=%b",
                         name, i, cnt15, wrap15, sf15, e15.cnt, e15.wrap, e15.sat_flag);
            end
        end
    endtask

    task automatic test_count_up_wrap();
        stim_t seq[$];
        int    up_seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        seq.push_back(mk(1, 0, 0, 0, 1, 0, 0));
        run_seq("up_reset", seq);
        seq = {};
        for (int i = 0; i < 12; i++) begin
            seq = {mk(0, 0, 0, 1, 1, 0, 0)};
            run_seq("up_wrap", seq);
            checks++;
            if (int'(cnt9) != up_seq[i] || wrap9 !== (up_seq[i] == 0)) begin
                errors++;
                $display("FAIL up_table step %0d: got cnt=%0d wrap=%b, want cnt=%0d wrap=%b",
                         i, cnt9, wrap9, up_seq[i], up_seq[i] == 0);
            end
        end
    endtask

    task automatic test_count_down_wrap();
        stim_t seq[$];
        seq.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) seq.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        run_seq("down_wrap", seq);
    endtask

    task automatic test_saturate_clear();
        stim_t seq[$];
        seq.push_back(mk(0, 0, 1, 0, 1, 1, 7));
        for (int i = 0; i < 5; i++) seq.push_back(mk(0, 0, 0, 1, 1, 1, 0));
        seq.push_back(mk(0, 1, 0, 1, 1, 1, 0));
        seq.push_back(mk(0, 0, 0, 1, 0, 1, 0));
        seq.push_back(mk(0, 0, 0, 1, 0, 1, 0));
        seq.push_back(mk(0, 1, 1, 1, 0, 0, 5));
        run_seq("sat_clr", seq);
    endtask

    task automatic test_load_clamp();
        stim_t seq[$];
        seq.push_back(mk(0, 0, 1, 1, 1, 0, 13));
        seq.push_back(mk(0, 0, 1, 1, 1, 0, 15));
        seq.push_back(mk(0, 0, 1, 0, 0, 0, 3));
        seq.push_back(mk(0, 0, 0, 0, 1, 0, 0));
        run_seq("load_clamp", seq);
    endtask

    task automatic test_reset_priority();
        stim_t seq[$];
        seq.push_back(mk(0, 0, 1, 0, 1, 1, 9));
        seq.push_back(mk(0, 0, 0, 1, 1, 1, 0));
        seq.push_back(mk(0, 0, 1, 0, 1, 1, 6));
        seq.push_back(mk(1, 1, 1, 1, 1, 0, 6));
        for (int i = 0; i < 3; i++) seq.push_back(mk(0, 0, 0, 0, 1, 0, 0));
        run_seq("rst_prio", seq);
    endtask

    task automatic test_full_range();
        stim_t seq[$];
        seq.push_back(mk(0, 0, 1, 0, 1, 0, 15));
        seq.push_back(mk(0, 0, 0, 1, 1, 0, 0));
        seq.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 1, 0, 1, 1, 15));
        seq.push_back(mk(0, 0, 0, 1, 1, 1, 0));
        seq.push_back(mk(0, 0, 0, 1, 1, 1, 0));
        run_seq("full_range", seq);
        checks++;
        if (cnt15 !== 4'd15 || sf15 !== 1'b1) begin
            errors++;
            $display("FAIL full_range_sat15: got cnt=%0d sf=%b, want cnt=15 sf=1", cnt15, sf15);
        end
    endtask

    task automatic test_back_to_back();
        stim_t seq[$];
        seq.push_back(mk(0, 0, 1, 0, 1, 0, 9));
        seq.push_back(mk(0, 0, 0, 1, 1, 0, 0));
        seq.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 0, 1, 1, 0, 0));
        seq.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        run_seq("back_to_back", seq);
    endtask

    initial begin
        apply(mk(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        test_reset();
        test_count_up_wrap();
        test_count_down_wrap();
        test_saturate_clear();
        test_load_clamp();
        test_reset_priority();
        test_full_range();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_counter_updown
